// File: rtl/laser_enable_sequencer.sv
// Laser power-enable / TA-shutdown safety sequencer: power-up, settle, TA release,
// armed operation, fault latching and the clear handshake back to idle.
module laser_enable_sequencer #(
  parameter int unsigned PWR_SETTLE_CYCLES    = 2500,
  parameter int unsigned PWR_TIMEOUT_CYCLES   = 250000,
  parameter int unsigned TA_DELAY_CYCLES      = 250,
  parameter int unsigned CLEAR_HOLDOFF_CYCLES = 25000,
  parameter int unsigned CNT_W                = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable_req,
  input  logic       enable_error_check,
  input  logic       clear_req,
  input  logic       laser_ready,
  input  logic       pwr_good,
  input  logic       pulse_lower_fail,
  input  logic       pulse_upper_fail,
  input  logic       rate_lower_fail,
  input  logic       current_fail,
  output logic       laser_pwr_en,
  output logic       ta_shutdown,
  output logic       clear_fail,
  output logic       armed,
  output logic       fault_latched,
  output logic [4:0] fault_cause,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_TA_DELAY = 3'd2,
    ST_ARMED    = 3'd3,
    ST_FAULT    = 3'd4,
    ST_CLEAR    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PWR_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(PWR_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TA_LAST     = CNT_W'(TA_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CLEAR_HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [1:0]       sync_q;
  logic [4:0]       cause_q, cause_d;
  logic             pwr_en_q, pwr_en_d;
  logic             clear_fail_q, clear_fail_d;
  logic             armed_q, armed_d;
  logic             fault_latched_q, fault_latched_d;
  logic             pwr_good_s;
  logic             pf, rf;
  logic [4:0]       live_c;

  assign pwr_good_s = sync_q[1];
  assign pf         = enable_error_check & (pulse_lower_fail | pulse_upper_fail);
  assign rf         = enable_error_check & rate_lower_fail;
  // {pwr_timeout, pwr_lost, current, rate, pulse} as seen in the current cycle
  assign live_c     = {1'b0, ~pwr_good_s, current_fail, rf, pf};

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_inc = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + CNT_W'(1);

  // Next-state, counter and sticky-cause logic.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_inc;
    tmo_d   = tmo_inc;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (enable_req && laser_ready) state_d = ST_PWR_WAIT;
      end
      ST_PWR_WAIT: begin
        cnt_d = pwr_good_s ? cnt_inc : '0;
        if (tmo_q == TMO_LAST) begin
          state_d    = ST_FAULT;
          cause_d[4] = 1'b1;
        end else if (!enable_req) begin
          state_d = ST_IDLE;
        end else if (pwr_good_s && (cnt_q == SETTLE_LAST)) begin
          state_d = ST_TA_DELAY;
        end
      end
      ST_TA_DELAY: begin
        if (!pwr_good_s || current_fail) begin
          state_d = ST_FAULT;
          cause_d = cause_q | (live_c & 5'b01100);
        end else if (!enable_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TA_LAST) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (|live_c) begin
          state_d = ST_FAULT;
          cause_d = cause_q | live_c;
        end else if (!enable_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        // Supply loss is expected once power is removed, so only limit faults accumulate.
        cause_d = cause_q | (live_c & 5'b00111);
        if (clear_req && !enable_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_q == HOLD_LAST) begin
          if (!pf && !rf && !current_fail && pwr_good_s) begin
            state_d = ST_IDLE;
            cause_d = '0;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: state_d = ST_FAULT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end

    pwr_en_d        = (state_q == ST_PWR_WAIT) || (state_q == ST_TA_DELAY) ||
                      (state_q == ST_ARMED);
    clear_fail_d    = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
    armed_d         = (state_d == ST_ARMED);
    fault_latched_d = (state_d == ST_FAULT) || (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      tmo_q           <= '0;
      sync_q          <= '0;
      cause_q         <= '0;
      pwr_en_q        <= 1'b0;
      clear_fail_q    <= 1'b0;
      armed_q         <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      sync_q          <= {sync_q[0], pwr_good};
      cause_q         <= cause_d;
      pwr_en_q        <= pwr_en_d;
      clear_fail_q    <= clear_fail_d;
      armed_q         <= armed_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  // Shutdown bypasses the register so a fault kills the TA in the cycle it appears.
  assign ta_shutdown   = (state_q != ST_ARMED) | pf | rf | current_fail;
  assign laser_pwr_en  = pwr_en_q;
  assign clear_fail    = clear_fail_q;
  assign armed         = armed_q;
  assign fault_latched = fault_latched_q;
  assign fault_cause   = cause_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_laser_enable_sequencer.sv
// Bench for laser_enable_sequencer: vector table, corner sequences and random
// stimulus, all checked against a cycles-in-state reference model.
module tb_laser_enable_sequencer;

  localparam int S  = 8;
  localparam int T  = 40;
  localparam int TA = 5;
  localparam int H  = 12;

  logic clk = 1'b0;
  logic rstn;
  logic enable_req, enable_error_check, clear_req, laser_ready, pwr_good;
  logic pulse_lower_fail, pulse_upper_fail, rate_lower_fail, current_fail;
  logic laser_pwr_en, ta_shutdown, clear_fail, armed, fault_latched;
  logic [4:0] fault_cause;
  logic [2:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;

  laser_enable_sequencer #(
    .PWR_SETTLE_CYCLES(S), .PWR_TIMEOUT_CYCLES(T), .TA_DELAY_CYCLES(TA),
    .CLEAR_HOLDOFF_CYCLES(H), .CNT_W(20)
  ) dut (
    .clk(clk), .rstn(rstn),
    .enable_req(enable_req), .enable_error_check(enable_error_check),
    .clear_req(clear_req), .laser_ready(laser_ready), .pwr_good(pwr_good),
    .pulse_lower_fail(pulse_lower_fail), .pulse_upper_fail(pulse_upper_fail),
    .rate_lower_fail(rate_lower_fail), .current_fail(current_fail),
    .laser_pwr_en(laser_pwr_en), .ta_shutdown(ta_shutdown), .clear_fail(clear_fail),
    .armed(armed), .fault_latched(fault_latched), .fault_cause(fault_cause),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // Reference model: state number, cycles spent in it, consecutive good-supply run.
  int       m_state, m_elapsed, m_run;
  bit [1:0] m_sync;
  bit [4:0] m_cause;
  bit       m_pwr_en, m_clear_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_run = 0; m_sync = 2'b00;
    m_cause = '0; m_pwr_en = 1'b0; m_clear_fail = 1'b0;
  endtask

  function automatic bit g_pf();
    return enable_error_check & (pulse_lower_fail | pulse_upper_fail);
  endfunction
  function automatic bit g_rf();
    return enable_error_check & rate_lower_fail;
  endfunction

  task automatic model_step();
    bit pgs, pf, rf, cf;
    int nxt, cyc, run;
    pgs = m_sync[1];
    pf  = g_pf();
    rf  = g_rf();
    cf  = current_fail;
    cyc = m_elapsed + 1;
    run = pgs ? m_run + 1 : 0;
    nxt = m_state;
    case (m_state)
      0: if (enable_req && laser_ready) nxt = 1;
      1: if (cyc == T) begin nxt = 4; m_cause[4] = 1'b1; end
         else if (!enable_req) nxt = 0;
         else if (pgs && run == S) nxt = 2;
      2: if (!pgs || cf) begin
           nxt = 4;
           if (!pgs) m_cause[3] = 1'b1;
           if (cf)   m_cause[2] = 1'b1;
         end else if (!enable_req) nxt = 0;
         else if (cyc == TA) nxt = 3;
      3: if (!pgs || cf || rf || pf) begin
           nxt = 4;
           m_cause = m_cause | {1'b0, !pgs, cf, rf, pf};
         end else if (!enable_req) nxt = 0;
      4: begin
           m_cause = m_cause | {2'b00, cf, rf, pf};
           if (clear_req && !enable_req) nxt = 5;
         end
      5: if (cyc == H) begin
           if (!pf && !rf && !cf && pgs) begin nxt = 0; m_cause = '0; end
           else nxt = 4;
         end
      default: nxt = 4;
    endcase
    m_pwr_en     = (m_state >= 1 && m_state <= 3);
    m_clear_fail = (m_state == 4 && nxt == 5);
    if (nxt != m_state) begin m_elapsed = 0; m_run = 0; end
    else begin m_elapsed = cyc; m_run = run; end
    m_state = nxt;
    m_sync  = {m_sync[0], pwr_good};
  endtask

  task automatic check_outputs();
    chk("seq_state", 32'(seq_state), 32'(m_state));
    chk("armed", 32'(armed), 32'(m_state == 3));
    chk("fault_latched", 32'(fault_latched), 32'(m_state == 4 || m_state == 5));
    chk("laser_pwr_en", 32'(laser_pwr_en), 32'(m_pwr_en));
    chk("clear_fail", 32'(clear_fail), 32'(m_clear_fail));
    chk("fault_cause", 32'(fault_cause), 32'(m_cause));
    chk("ta_shutdown", 32'(ta_shutdown),
        32'((m_state != 3) || g_pf() || g_rf() || current_fail));
  endtask

  // One clock: check mid-cycle, advance model on the edge, drop the clear pulse.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    clear_req = 1'b0;
  endtask

  task automatic reach_armed();
    enable_error_check = 1'b1; laser_ready = 1'b1; pwr_good = 1'b1;
    {current_fail, rate_lower_fail, pulse_upper_fail, pulse_lower_fail} = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if (m_state == 3) break;
      if (m_state == 4) begin enable_req = 1'b0; clear_req = 1'b1; end
      else if (m_state == 5) enable_req = 1'b0;
      else enable_req = 1'b1;
      tick();
    end
    chk("reach_armed", 32'(seq_state), 32'(3));
  endtask

  typedef struct {
    bit       en, eec, clr, rdy, pg;
    bit [3:0] flt;        // {current, rate_lower, pulse_upper, pulse_lower}
    int       cycles;
    int       exp_state;
    bit [4:0] exp_cause;
    bit       exp_pwr_en;
  } vec_t;

  vec_t tbl [37];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,1,0,1,1,4'b0000, 1,1,5'b00000,0};
    tbl[1]  = '{1,1,0,1,1,4'b0000, 8,1,5'b00000,1};
    tbl[2]  = '{1,1,0,1,1,4'b0000, 1,2,5'b00000,1};
    tbl[3]  = '{1,1,0,1,1,4'b0000, 4,2,5'b00000,1};
    tbl[4]  = '{1,1,0,1,1,4'b0000, 1,3,5'b00000,1};
    tbl[5]  = '{1,1,0,1,1,4'b1000, 1,4,5'b00100,1};
    tbl[6]  = '{1,1,0,1,1,4'b0000, 1,4,5'b00100,0};
    tbl[7]  = '{1,1,1,1,1,4'b0000, 1,4,5'b00100,0};
    tbl[8]  = '{0,1,1,1,1,4'b0000, 1,5,5'b00100,0};
    tbl[9]  = '{0,1,0,1,1,4'b0000,11,5,5'b00100,0};
    tbl[10] = '{0,1,0,1,1,4'b0000, 1,0,5'b00000,0};
    tbl[11] = '{1,1,0,0,1,4'b0000, 3,0,5'b00000,0};
    tbl[12] = '{1,1,0,1,0,4'b0000, 1,1,5'b00000,0};
    tbl[13] = '{1,1,0,1,0,4'b0000,39,1,5'b00000,1};
    tbl[14] = '{1,1,0,1,0,4'b0000, 1,4,5'b10000,1};
    tbl[15] = '{0,1,1,1,1,4'b0000, 1,5,5'b10000,0};
    tbl[16] = '{0,1,0,1,1,4'b0000,11,5,5'b10000,0};
    tbl[17] = '{0,1,0,1,1,4'b0000, 1,0,5'b00000,0};
    tbl[18] = '{1,0,0,1,1,4'b0010, 1,1,5'b00000,0};
    tbl[19] = '{1,0,0,1,1,4'b0010, 8,2,5'b00000,1};
    tbl[20] = '{1,0,0,1,1,4'b0010, 5,3,5'b00000,1};
    tbl[21] = '{1,0,0,1,1,4'b0010, 3,3,5'b00000,1};
    tbl[22] = '{1,1,0,1,1,4'b0010, 1,4,5'b00001,1};
    tbl[23] = '{0,1,1,1,1,4'b0100, 1,5,5'b00011,0};
    tbl[24] = '{0,1,0,1,1,4'b0100,12,4,5'b00011,0};
    tbl[25] = '{0,1,1,1,1,4'b0000, 1,5,5'b00011,0};
    tbl[26] = '{0,1,0,1,1,4'b0000,12,0,5'b00000,0};
    tbl[27] = '{1,1,0,1,1,4'b0000, 1,1,5'b00000,0};
    tbl[28] = '{1,1,0,1,1,4'b0000, 8,2,5'b00000,1};
    tbl[29] = '{1,1,0,1,1,4'b0000, 5,3,5'b00000,1};
    tbl[30] = '{1,1,0,1,0,4'b0000, 1,3,5'b00000,1};
    tbl[31] = '{1,1,0,1,0,4'b0000, 1,3,5'b00000,1};
    tbl[32] = '{1,1,0,1,0,4'b0000, 1,4,5'b01000,1};
    tbl[33] = '{0,1,1,1,1,4'b0000, 1,5,5'b01000,0};
    tbl[34] = '{0,1,0,1,1,4'b0000,12,0,5'b00000,0};
    tbl[35] = '{1,1,0,1,1,4'b0000, 1,1,5'b00000,0};
    tbl[36] = '{0,1,0,1,1,4'b0000, 1,0,5'b00000,1};

    rstn = 1'b0;
    enable_req = 1'b0; enable_error_check = 1'b0; clear_req = 1'b0;
    laser_ready = 1'b0; pwr_good = 1'b0;
    {current_fail, rate_lower_fail, pulse_upper_fail, pulse_lower_fail} = 4'b0000;
    model_reset();
    #22;
    chk("rst_seq_state", 32'(seq_state), 32'(0));
    chk("rst_laser_pwr_en", 32'(laser_pwr_en), 32'(0));
    chk("rst_ta_shutdown", 32'(ta_shutdown), 32'(1));
    chk("rst_clear_fail", 32'(clear_fail), 32'(0));
    chk("rst_armed", 32'(armed), 32'(0));
    chk("rst_fault_latched", 32'(fault_latched), 32'(0));
    chk("rst_fault_cause", 32'(fault_cause), 32'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 37; i++) begin
      enable_req = tbl[i].en; enable_error_check = tbl[i].eec; clear_req = tbl[i].clr;
      laser_ready = tbl[i].rdy; pwr_good = tbl[i].pg;
      {current_fail, rate_lower_fail, pulse_upper_fail, pulse_lower_fail} = tbl[i].flt;
      for (int k = 0; k < tbl[i].cycles; k++) tick();
      chk($sformatf("vec%0d_state", i), 32'(seq_state), 32'(tbl[i].exp_state));
      chk($sformatf("vec%0d_cause", i), 32'(fault_cause), 32'(tbl[i].exp_cause));
      chk($sformatf("vec%0d_pwr_en", i), 32'(laser_pwr_en), 32'(tbl[i].exp_pwr_en));
    end

    for (int n = 0; n < 2500; n++) begin
      enable_req         = ($urandom_range(0, 99) < 95);
      enable_error_check = ($urandom_range(0, 99) < 80);
      clear_req          = ($urandom_range(0, 99) < 15);
      laser_ready        = ($urandom_range(0, 99) < 95);
      pwr_good           = ($urandom_range(0, 99) < 97);
      pulse_lower_fail   = ($urandom_range(0, 199) < 2);
      pulse_upper_fail   = ($urandom_range(0, 199) < 2);
      rate_lower_fail    = ($urandom_range(0, 199) < 2);
      current_fail       = ($urandom_range(0, 199) < 2);
      tick();
    end

    // Fault coinciding with enable drop must still land in FAULT.
    reach_armed();
    enable_req = 1'b0; current_fail = 1'b1;
    tick();
    current_fail = 1'b0;
    chk("drop_with_fault_state", 32'(seq_state), 32'(4));
    chk("drop_with_fault_cause", 32'(fault_cause), 32'(5'b00100));

    // Asynchronous reset between clock edges while ARMED.
    reach_armed();
    tick();
    #3;
    rstn = 1'b0;
    #1;
    chk("async_laser_pwr_en", 32'(laser_pwr_en), 32'(0));
    chk("async_ta_shutdown", 32'(ta_shutdown), 32'(1));
    chk("async_seq_state", 32'(seq_state), 32'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    chk("post_reset_state", 32'(seq_state), 32'(0));
    chk("post_reset_cause", 32'(fault_cause), 32'(0));
    for (int k = 0; k < 20; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
